mean_8: RTL and testbench

- Pipelined arithmetic mean of eight unsigned WID-bit samples, presented in parallel every clock.
- Fully pipelined adder tree followed by a divide-by-8 stage; accepts a new sample set every cycle.
- Used as a streaming averaging/smoothing block inside datapath logic; no handshake beyond an output-valid flag.

---
 rtl/mean_8.sv | 65 ++++++
 tb/tb_mean_8.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mean_8.sv
// Pipelined mean of eight unsigned samples: 3-level adder tree, then divide by 8.
// Define MEAN8_ROUND_EN for round-half-up instead of truncation.
module mean_8 #(
  parameter int WID = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WID-1:0] in_000,
  input  logic [WID-1:0] in_001,
  input  logic [WID-1:0] in_002,
  input  logic [WID-1:0] in_003,
  input  logic [WID-1:0] in_004,
  input  logic [WID-1:0] in_005,
  input  logic [WID-1:0] in_006,
  input  logic [WID-1:0] in_007,
  output logic [WID-1:0] mean_out,
  output logic           mean_valid
);

  logic [WID:0]   r_s0;
  logic [WID:0]   r_s1;
  logic [WID:0]   r_s2;
  logic [WID:0]   r_s3;
  logic [WID+1:0] r_t0;
  logic [WID+1:0] r_t1;
  logic [WID+2:0] r_sum;
  logic [WID-1:0] r_mean;
  logic [3:0]     r_vld;
  logic [WID-1:0] w_mean;

`ifdef MEAN8_ROUND_EN
  // Extra headroom bit keeps the +4 from wrapping before the shift.
  assign w_mean = WID'(({1'b0, r_sum} + (WID+4)'(4)) >> 3);
`else
  assign w_mean = WID'(r_sum >> 3);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0   <= '0;
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_t0   <= '0;
      r_t1   <= '0;
      r_sum  <= '0;
      r_mean <= '0;
      r_vld  <= '0;
    end else begin
      r_s0   <= {1'b0, in_000} + {1'b0, in_001};
      r_s1   <= {1'b0, in_002} + {1'b0, in_003};
      r_s2   <= {1'b0, in_004} + {1'b0, in_005};
      r_s3   <= {1'b0, in_006} + {1'b0, in_007};
      r_t0   <= {1'b0, r_s0} + {1'b0, r_s1};
      r_t1   <= {1'b0, r_s2} + {1'b0, r_s3};
      r_sum  <= {1'b0, r_t0} + {1'b0, r_t1};
      r_mean <= w_mean;
      r_vld  <= {r_vld[2:0], 1'b1};
    end
  end

  assign mean_out   = r_mean;
  assign mean_valid = r_vld[3];

endmodule

// File: tb/tb_mean_8.sv
// Self-checking bench for mean_8: directed and random sample sets
// compared against an arithmetic reference model with a 4-edge lag.
module tb_mean_8;

  localparam int W = 16;

`ifdef MEAN8_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_v [8];
  logic [W-1:0] mean_out;
  logic         mean_valid;

  int n_chk  = 0;
  int n_fail = 0;
  int n_edge = 0;
  logic [W-1:0] hist [$];

  always #5 clk = ~clk;

  mean_8 #(.WID(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_000    (in_v[0]),
    .in_001    (in_v[1]),
    .in_002    (in_v[2]),
    .in_003    (in_v[3]),
    .in_004    (in_v[4]),
    .in_005    (in_v[5]),
    .in_006    (in_v[6]),
    .in_007    (in_v[7]),
    .mean_out  (mean_out),
    .mean_valid(mean_valid)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_mean();
    longint s;
    longint m;
    s = 0;
    for (int i = 0; i < 8; i++) s += longint'(in_v[i]);
    m = ROUND ? (s + 4) / 8 : s / 8;
    return W'(m);
  endfunction

  // One clock: record the model's answer for this sample set, then check
  // the output that was sampled three edges earlier.
  task automatic tick();
    logic [W-1:0] e;
    e = ref_mean();
    @(posedge clk);
    #1;
    hist.push_back(e);
    n_edge++;
    chk("valid", longint'(mean_valid), longint'(n_edge >= 4));
    if (n_edge >= 4)
      chk("mean", longint'(mean_out), longint'(hist[n_edge-4]));
  endtask

  task automatic set_all(input logic [W-1:0] v);
    for (int i = 0; i < 8; i++) in_v[i] = v;
  endtask

  // Assert reset away from any edge, check it acts at once, release after an edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mean", longint'(mean_out), 0);
    chk("rst_valid", longint'(mean_valid), 0);
    @(posedge clk);
    #1;
    chk("rst_hold_valid", longint'(mean_valid), 0);
    rst = 1'b0;
    hist.delete();
    n_edge = 0;
  endtask

  initial begin
    set_all('0);
    #1;
    chk("init_mean", longint'(mean_out), 0);
    chk("init_valid", longint'(mean_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Static set 10..17
    for (int i = 0; i < 8; i++) in_v[i] = W'(10 + i);
    repeat (4) tick();
    chk("static", longint'(mean_out), ROUND ? 14 : 13);

    // Ramp from a fresh reset
    do_reset();
    for (int k = 0; k < 100; k++) begin
      for (int i = 0; i < 8; i++) in_v[i] = W'(10 + i + k);
      tick();
      if (k >= 3)
        chk("ramp", longint'(mean_out), longint'((ROUND ? 14 : 13) + k - 3));
    end

    // Extremes
    set_all('1);
    repeat (4) tick();
    chk("all_max", longint'(mean_out), longint'({W{1'b1}}));
    set_all('0);
    repeat (4) tick();
    chk("all_zero", longint'(mean_out), 0);
    set_all('0);
    in_v[0] = '1;
    repeat (4) tick();
    chk("one_max", longint'(mean_out), ROUND ? 'h2000 : 'h1FFF);
    set_all(W'('h1234));
    repeat (4) tick();
    chk("exact", longint'(mean_out), 'h1234);

    // Back-to-back distinct sets
    set_all(W'(8));
    tick();
    set_all(W'(16));
    tick();
    set_all(W'(24));
    tick();
    set_all('0);
    tick();
    chk("b2b_8", longint'(mean_out), 8);
    tick();
    chk("b2b_16", longint'(mean_out), 16);
    tick();
    chk("b2b_24", longint'(mean_out), 24);

    // Random stream, reset mid-stream, random again
    for (int k = 0; k < 150; k++) begin
      for (int i = 0; i < 8; i++) in_v[i] = W'($urandom);
      tick();
    end
    do_reset();
    for (int k = 0; k < 150; k++) begin
      for (int i = 0; i < 8; i++) in_v[i] = W'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
